// File: rtl/floor_request_input.sv
// Floor-call pushbutton front end: 2-flop sync, tick-sampled debounce FSM per button, request latch.
// Optional FLOOR_REQ_CANCEL_EN: a fresh press on an already-latched floor cancels that request.
module floor_request_input #(
    parameter int N_FLOORS        = 8,
    parameter int DEBOUNCE_CYCLES = 100_000,
    parameter int STABLE_TICKS    = 3
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [N_FLOORS-1:0] BTN_RAW,
    input  logic [3:0]          floor,
    input  logic                arrive,
    output logic [N_FLOORS-1:0] floor_btn,
    output logic                req_any,
    output logic                btn_event
);

    localparam int TICK_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CNT_W  = $clog2(STABLE_TICKS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        REL       = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } db_state_t;

    logic [N_FLOORS-1:0] sync1_r;
    logic [N_FLOORS-1:0] sync2_r;
    logic [TICK_W-1:0]   tick_cnt_r;
    logic                tick_s;
    db_state_t           state_r [N_FLOORS];
    logic [CNT_W-1:0]    cnt_r   [N_FLOORS];
    logic [N_FLOORS-1:0] press_s;
    logic [N_FLOORS-1:0] clr_s;
    logic [N_FLOORS-1:0] next_btn_s;
    logic                set_any_s;

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_r <= {N_FLOORS{1'b0}};
            sync2_r <= {N_FLOORS{1'b0}};
        end else begin
            sync1_r <= BTN_RAW;
            sync2_r <= sync1_r;
        end
    end

    // Shared sample-tick divider; tick marks the cycle the counter wraps
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Press strobe: fires on the tick that accepts a new pressed level
    always_comb begin
        for (int i = 0; i < N_FLOORS; i++) begin
            press_s[i] = 1'b0;
            if (tick_s && sync2_r[i]) begin
                case (state_r[i])
                    REL:       press_s[i] = (STABLE_TICKS == 1);
                    PRESS_CHK: press_s[i] = (cnt_r[i] == CNT_LAST);
                    default:   press_s[i] = 1'b0;
                endcase
            end else begin
                press_s[i] = 1'b0;
            end
        end
    end

    // Per-button debounce FSM; state only moves on a sample tick
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_FLOORS; i++) begin
                state_r[i] <= REL;
                cnt_r[i]   <= {CNT_W{1'b0}};
            end
        end else if (tick_s) begin
            for (int i = 0; i < N_FLOORS; i++) begin
                case (state_r[i])
                    REL: begin
                        if (sync2_r[i]) begin
                            if (STABLE_TICKS == 1) begin
                                state_r[i] <= HELD;
                            end else begin
                                state_r[i] <= PRESS_CHK;
                                cnt_r[i]   <= CNT_ONE;
                            end
                        end
                    end
                    PRESS_CHK: begin
                        if (!sync2_r[i]) begin
                            state_r[i] <= REL;
                        end else if (cnt_r[i] == CNT_LAST) begin
                            state_r[i] <= HELD;
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!sync2_r[i]) begin
                            if (STABLE_TICKS == 1) begin
                                state_r[i] <= REL;
                            end else begin
                                state_r[i] <= REL_CHK;
                                cnt_r[i]   <= CNT_ONE;
                            end
                        end
                    end
                    REL_CHK: begin
                        if (sync2_r[i]) begin
                            state_r[i] <= HELD;
                        end else if (cnt_r[i] == CNT_LAST) begin
                            state_r[i] <= REL;
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CNT_ONE;
                        end
                    end
                    default: state_r[i] <= REL;
                endcase
            end
        end
    end

    // Request next-state: arrival clear beats a coincident press
    always_comb begin
        for (int i = 0; i < N_FLOORS; i++) begin
            clr_s[i]      = arrive && (floor == 4'(i));
            next_btn_s[i] = floor_btn[i];
            if (clr_s[i]) begin
                next_btn_s[i] = 1'b0;
            end else if (press_s[i]) begin
`ifdef FLOOR_REQ_CANCEL_EN
                next_btn_s[i] = ~floor_btn[i];
`else
                next_btn_s[i] = 1'b1;
`endif
            end else begin
                next_btn_s[i] = floor_btn[i];
            end
        end
        set_any_s = |(next_btn_s & ~floor_btn);
    end

    // Registered request vector and new-request pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            floor_btn <= {N_FLOORS{1'b0}};
            btn_event <= 1'b0;
        end else begin
            floor_btn <= next_btn_s;
            btn_event <= set_any_s;
        end
    end

    assign req_any = |floor_btn;

endmodule

// File: tb/tb_floor_request_input.sv
// Bench for floor_request_input: directed scenarios plus random traffic, every cycle compared
// against a level/run-length reference model of debounce and request latching.
module tb_floor_request_input;

    localparam int N  = 8;
    localparam int DC = 4;
    localparam int ST = 3;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] BTN_RAW;
    logic [3:0] floor;
    logic       arrive;
    logic [7:0] floor_btn;
    logic       req_any;
    logic       btn_event;

    int tests = 0;
    int fails = 0;
    int ev_count = 0;

    // reference model state
    int         k;
    logic [7:0] d1, d2, acc;
    int         run_len [N];
    logic [7:0] exp_btn;
    logic       exp_ev;

    always #5 CLK = ~CLK;

    floor_request_input #(
        .N_FLOORS(N), .DEBOUNCE_CYCLES(DC), .STABLE_TICKS(ST)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .BTN_RAW(BTN_RAW), .floor(floor), .arrive(arrive),
        .floor_btn(floor_btn), .req_any(req_any), .btn_event(btn_event)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        k = 0; d1 = 8'h00; d2 = 8'h00; acc = 8'h00;
        exp_btn = 8'h00; exp_ev = 1'b0;
        for (int i = 0; i < N; i++) run_len[i] = 0;
    endtask

    // Accepted level flips after ST consecutive tick samples that disagree with it
    task automatic model_step();
        logic       tk;
        logic [7:0] syn;
        logic [7:0] nb;
        logic       pr;
        tk  = (k == DC - 1);
        k   = tk ? 0 : k + 1;
        syn = d2;
        d2  = d1;
        d1  = BTN_RAW;
        nb  = exp_btn;
        for (int i = 0; i < N; i++) begin
            pr = 1'b0;
            if (tk) begin
                if (syn[i] != acc[i]) begin
                    run_len[i]++;
                    if (run_len[i] == ST) begin
                        acc[i] = syn[i];
                        run_len[i] = 0;
                        pr = syn[i];
                    end
                end else begin
                    run_len[i] = 0;
                end
            end
            if (arrive && (int'(floor) == i)) nb[i] = 1'b0;
`ifdef FLOOR_REQ_CANCEL_EN
            else if (pr) nb[i] = ~exp_btn[i];
`else
            else if (pr) nb[i] = 1'b1;
`endif
        end
        exp_ev  = |(nb & ~exp_btn);
        exp_btn = nb;
    endtask

    task automatic step();
        @(posedge CLK);
        if (RST_N) model_step();
        @(negedge CLK);
        check("floor_btn", floor_btn, exp_btn);
        check("btn_event", {7'b0, btn_event}, {7'b0, exp_ev});
        check("req_any", {7'b0, req_any}, {7'b0, |exp_btn});
        if (btn_event) ev_count++;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic arrive_at(input logic [3:0] f);
        arrive = 1'b1;
        floor  = f;
        step();
        arrive = 1'b0;
    endtask

    initial begin
        int  set_cycle;
        bit  hit;
        bit  found;

        // 1: reset with buttons held
        RST_N = 1'b0; BTN_RAW = 8'h05; floor = 4'd0; arrive = 1'b0;
        model_reset();
        run(6);
        RST_N = 1'b1;
        run(8);
        check("t1_no_early_set", floor_btn, 8'h00);
        run(12);
        check("t1_held_set", floor_btn, 8'h05);
        BTN_RAW = 8'h00;
        run(20);
        arrive_at(4'd0);
        arrive_at(4'd2);
        check("t1_cleared", floor_btn, 8'h00);

        // 2: clean press of floor 3
        ev_count = 0; set_cycle = -1;
        BTN_RAW[3] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (floor_btn[3] && set_cycle < 0) set_cycle = c + 1;
        end
        check("t2_latency_ok", {7'b0, (set_cycle >= 1 && set_cycle <= 15)}, 8'h01);
        check("t2_floor_btn", floor_btn, 8'h08);
        check("t2_events", 8'(ev_count), 8'h01);
        check("t2_req_any", {7'b0, req_any}, 8'h01);
        BTN_RAW[3] = 1'b0;
        run(20);

        // 3: bounce on floor 2, phased so tick samples see it released
        ev_count = 0;
        for (int c = 0; c < 20; c++) begin
            BTN_RAW[2] = ((k % 2) == 0);
            step();
        end
        BTN_RAW[2] = 1'b0;
        run(16);
        check("t3_floor_btn", floor_btn, 8'h08);
        check("t3_events", 8'(ev_count), 8'h00);

        // 4: arrival clears only the matching floor
        BTN_RAW[5] = 1'b1; run(20);
        BTN_RAW[5] = 1'b0; run(20);
        check("t4_before", floor_btn, 8'h28);
        arrive_at(4'd5);
        check("t4_arrive5", floor_btn, 8'h08);
        arrive_at(4'd9);
        check("t4_arrive9", floor_btn, 8'h08);

        // 5: press of floor 1 completes in the arrival cycle
        ev_count = 0; hit = 1'b0;
        BTN_RAW[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (!hit && k == DC - 1 && d2[1] && !acc[1] && run_len[1] == ST - 1) begin
                arrive = 1'b1; floor = 4'd1; hit = 1'b1;
            end
            step();
            arrive = 1'b0;
        end
        check("t5_coincided", {7'b0, hit}, 8'h01);
        run(20);
        check("t5_bit1", floor_btn & 8'h02, 8'h00);
        check("t5_events", 8'(ev_count), 8'h00);
        BTN_RAW[1] = 1'b0;
        run(20);

        // 6: second press of floor 3
        ev_count = 0;
        BTN_RAW[3] = 1'b1; run(20);
        BTN_RAW[3] = 1'b0; run(20);
`ifdef FLOOR_REQ_CANCEL_EN
        check("t6_cancel", floor_btn, 8'h00);
`else
        check("t6_no_cancel", floor_btn, 8'h08);
`endif
        check("t6_events", 8'(ev_count), 8'h00);

        // 6b: async reset while floor 4 is mid-check
        BTN_RAW[6] = 1'b1; run(20);
        BTN_RAW[6] = 1'b0; BTN_RAW[4] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (!acc[4] && run_len[4] == 1) found = 1'b1;
        end
        check("t6_reached_press_chk", {7'b0, found}, 8'h01);
        RST_N = 1'b0;
        model_reset();
        #1;
        check("t6_async_clear", floor_btn, 8'h00);
        check("t6_async_req_any", {7'b0, req_any}, 8'h00);
        run(3);
        RST_N = 1'b1;
        run(24);
        check("t6_restart_set", floor_btn, 8'h10);
        BTN_RAW = 8'h00;
        run(20);

        // 7: random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) BTN_RAW[$urandom_range(0, 7)] ^= 1'b1;
            arrive = ($urandom_range(0, 11) == 0);
            floor  = 4'($urandom_range(0, 15));
            step();
            arrive = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
